rf_wb_ctrl: RTL and testbench
=============================

RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

Interface
REQ-001 Parameter DW, default 16, register data width.
REQ-002 Parameter NREG, default 16, number of architectural registers; index width RW = 4.
REQ-003 Parameter AW, default 5, width of the register-file address port.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: clk, rst_n.
REQ-005 Ports SHALL be, as name / direction / width / meaning:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  async active-low reset
- req0_valid  in  1  ALU write-back request
- req0_rd  in  RW  ALU destination index
- req0_data  in  DW  ALU result
- req0_ready  out  1  ALU request accepted this cycle
- req1_valid / req1_rd / req1_data / req1_ready  same widths, load write-back requester
- rsv_valid  in  1  issue stage reserves a destination
- rsv_rd  in  RW  index to reserve
- rsv_ready  out  1  reservation accepted this cycle
- q_rs, q_rt  in  RW  source indices being issued
- hazard  out  1  a queried source has a pending write
- wr_en  out  1  register-file write strobe
- wr_rd  out  AW  register-file write address; MSB zero-extended
- wr_data  out  DW  register-file write data
- sb_err  out  1  sticky: commit to an unreserved register

Function
REQ-006 The block SHALL grant at most one write-back request per cycle; a request is accepted when reqN_valid and reqN_ready are both 1 at posedge.
REQ-007 reqN_ready SHALL be combinational from the valids and the RR pointer; a single valid requester is always granted.
REQ-008 If both requesters are valid, the block SHALL grant the one not granted most recently; the pointer updates only on acceptance.
REQ-009 An accepted request SHALL appear on wr_en=1, wr_rd, wr_data for exactly the following cycle; latency 1; the register file samples at that cycle's negedge.
REQ-010 wr_en SHALL be 0 in any cycle following a cycle with no acceptance; wr_rd/wr_data hold their last value.
REQ-011 The block SHALL keep busy[NREG]: set at posedge on rsv_valid && rsv_ready for rsv_rd; clear at posedge on write-back acceptance for reqN_rd.
REQ-012 rsv_ready SHALL be 1 if busy[rsv_rd]=0, or if a write-back to rsv_rd is accepted in the same cycle.
REQ-013 Reserve and commit to the same index in one cycle: set wins; busy stays 1.
REQ-014 hazard SHALL equal busy[q_rs] | busy[q_rt], combinational, from registered busy only; no bypassing.
REQ-015 A write-back to an index with busy=0 SHALL still be written and SHALL set sb_err, which holds until reset.
REQ-016 A requester SHALL hold valid, rd and data stable until accepted; the block does not check this.

Reset
REQ-017 On rst_n=0, asynchronously: busy=0, RR pointer = "req1 last" (req0 wins first tie), wr_en=0, wr_rd=0, wr_data=0, sb_err=0.
REQ-018 reqN_ready and rsv_ready SHALL be 0 while rst_n=0; register-file contents are not affected.
REQ-019 A reset asserted mid-operation discards the pending output write; wr_en goes 0 immediately.

Structure
REQ-020 Package rf_ctrl_pkg SHALL hold DW, NREG, RW, AW and the requester-index encoding.
REQ-021 The two-input round-robin grant with pointer SHALL be sub-module rr_arb2; scoreboard and output register live in rf_wb_ctrl.

Verification
REQ-022 Reserve r3, then req0 rd=3 data=0x1234 -> next cycle wr_en=1, wr_rd=5'd3, wr_data=0x1234; hazard for q_rs=3 drops the cycle after acceptance.
REQ-023 Both valid for 4 cycles after reset (rd=1 / rd=2) -> grants req0, req1, req0, req1; wr_rd 1,2,1,2.
REQ-024 Reserve r7 while busy[7]=1 with no commit -> rsv_ready=0; the same cycle with req1 rd=7 accepted -> rsv_ready=1 and busy[7] stays 1.
REQ-025 req0 rd=9 with busy[9]=0 -> write occurs; sb_err=1 and remains 1 through later traffic until rst_n pulse.
REQ-026 Assert rst_n=0 in the cycle wr_en=1 -> wr_en, busy, sb_err clear without clk edge; the first tie after release grants req0.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared widths and requester encoding for the register-file write-back controller.
package rf_ctrl_pkg;
  localparam int DW   = 16;
  localparam int NREG = 16;
  localparam int RW   = 4;
  localparam int AW   = 5;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_idx_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant; a tie goes to the requester not granted last.
module rr_arb2
  import rf_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);
  req_idx_e r_last;
  logic     w_pick0;

  // Grant doubles as acceptance, so it is forced low while reset is held.
  assign w_pick0 = i_valid[0] && (!i_valid[1] || (r_last == REQ1));
  assign o_grant = {i_valid[1] && !w_pick0, w_pick0} & {2{rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_last <= REQ1;
    else if (o_grant[0]) r_last <= REQ0;
    else if (o_grant[1]) r_last <= REQ1;
  end
endmodule

// File: rtl/rf_wb_ctrl.sv
// Write-back arbitration, destination scoreboard and registered register-file write port.
module rf_wb_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int DW   = rf_ctrl_pkg::DW,
  parameter int NREG = rf_ctrl_pkg::NREG,
  parameter int AW   = rf_ctrl_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [RW-1:0] req0_rd,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [RW-1:0] req1_rd,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic          rsv_valid,
  input  logic [RW-1:0] rsv_rd,
  output logic          rsv_ready,
  input  logic [RW-1:0] q_rs,
  input  logic [RW-1:0] q_rt,
  output logic          hazard,
  output logic          wr_en,
  output logic [AW-1:0] wr_rd,
  output logic [DW-1:0] wr_data,
  output logic          sb_err
);
  logic [1:0]           w_gnt;
  logic [1:0][RW-1:0]   w_rd;
  logic [1:0][DW-1:0]   w_data;
  logic                 w_acc;
  logic [RW-1:0]        w_crd;
  logic [DW-1:0]        w_cdata;
  logic                 w_rsv;
  logic [NREG-1:0]      w_set, w_clr;

  logic [NREG-1:0]      r_busy;
  logic                 r_wr_en;
  logic [AW-1:0]        r_wr_rd;
  logic [DW-1:0]        r_wr_data;
  logic                 r_sb_err;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid ({req1_valid, req0_valid}),
    .o_grant (w_gnt)
  );

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];

  assign w_rd    = {req1_rd, req0_rd};
  assign w_data  = {req1_data, req0_data};
  assign w_acc   = |w_gnt;
  assign w_crd   = w_gnt[1] ? w_rd[1] : w_rd[0];
  assign w_cdata = w_gnt[1] ? w_data[1] : w_data[0];

  // A commit landing on the same index frees the slot for a same-cycle reservation.
  assign rsv_ready = rst_n && (!r_busy[rsv_rd] || (w_acc && (w_crd == rsv_rd)));
  assign w_rsv     = rsv_valid && rsv_ready;

  assign hazard = r_busy[q_rs] | r_busy[q_rt];

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_acc) w_clr[w_crd]  = 1'b1;
    if (w_rsv) w_set[rsv_rd] = 1'b1;
  end

  // Set is applied after clear so a same-index reserve+commit leaves the entry busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= '0;
      r_sb_err <= 1'b0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
      if (w_acc && !r_busy[w_crd]) r_sb_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_rd   <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_acc;
      if (w_acc) begin
        r_wr_rd   <= AW'(w_crd);
        r_wr_data <= w_cdata;
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_rd   = r_wr_rd;
  assign wr_data = r_wr_data;
  assign sb_err  = r_sb_err;
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Self-checking bench: directed vector table, corner sequences, randomized traffic vs reference model.
module tb_rf_wb_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req1_valid, rsv_valid;
  logic [3:0]  req0_rd, req1_rd, rsv_rd, q_rs, q_rt;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, rsv_ready, hazard, wr_en, sb_err;
  logic [4:0]  wr_rd;
  logic [15:0] wr_data;

  int errs = 0;
  int checks = 0;

  rf_wb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .rsv_ready(rsv_ready),
    .q_rs(q_rs), .q_rt(q_rt), .hazard(hazard),
    .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v0; logic [3:0] rd0; logic [15:0] d0;
    logic v1; logic [3:0] rd1; logic [15:0] d1;
    logic rv; logic [3:0] rrd; logic [3:0] qs; logic [3:0] qt;
    logic e_r0; logic e_r1; logic e_rsv; logic e_hz;
    logic e_we; logic [4:0] e_wrd; logic [15:0] e_wd; logic e_sb;
  } vec_t;

  vec_t tbl[9];

  function automatic vec_t mk(
    input logic v0, input logic [3:0] rd0, input logic [15:0] d0,
    input logic v1, input logic [3:0] rd1, input logic [15:0] d1,
    input logic rv, input logic [3:0] rrd, input logic [3:0] qs, input logic [3:0] qt,
    input logic e_r0, input logic e_r1, input logic e_rsv, input logic e_hz,
    input logic e_we, input logic [4:0] e_wrd, input logic [15:0] e_wd, input logic e_sb);
    vec_t v;
    v.v0 = v0; v.rd0 = rd0; v.d0 = d0; v.v1 = v1; v.rd1 = rd1; v.d1 = d1;
    v.rv = rv; v.rrd = rrd; v.qs = qs; v.qt = qt;
    v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_rsv = e_rsv; v.e_hz = e_hz;
    v.e_we = e_we; v.e_wrd = e_wrd; v.e_wd = e_wd; v.e_sb = e_sb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [3:0] rd0, input logic [15:0] d0,
                       input logic v1, input logic [3:0] rd1, input logic [15:0] d1,
                       input logic rv, input logic [3:0] rrd, input logic [3:0] qs, input logic [3:0] qt);
    req0_valid = v0; req0_rd = rd0; req0_data = d0;
    req1_valid = v1; req1_rd = rd1; req1_data = d1;
    rsv_valid = rv; rsv_rd = rrd; q_rs = qs; q_rt = qt;
  endtask

  task automatic comb_chk(input string t, input logic r0, input logic r1, input logic rs, input logic hz);
    chk({t, ".req0_ready"}, 32'(req0_ready), 32'(r0));
    chk({t, ".req1_ready"}, 32'(req1_ready), 32'(r1));
    chk({t, ".rsv_ready"},  32'(rsv_ready),  32'(rs));
    chk({t, ".hazard"},     32'(hazard),     32'(hz));
  endtask

  task automatic seq_chk(input string t, input logic we, input logic [4:0] wrd, input logic [15:0] wd, input logic sb);
    chk({t, ".wr_en"},   32'(wr_en),   32'(we));
    chk({t, ".wr_rd"},   32'(wr_rd),   32'(wrd));
    chk({t, ".wr_data"}, 32'(wr_data), 32'(wd));
    chk({t, ".sb_err"},  32'(sb_err),  32'(sb));
  endtask

  // Reference model: a set of pending destinations plus who won last.
  bit          m_busy[16];
  int          m_last;
  bit          m_sb, m_we;
  logic [4:0]  m_wrd;
  logic [15:0] m_wd;

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_last = 1; m_sb = 1'b0; m_we = 1'b0; m_wrd = '0; m_wd = '0;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [3:0] pick_rd();
    logic [3:0] r;
    r = 4'($urandom_range(0, 15));
    for (int k = 0; k < 6 && !m_busy[r]; k++) r = 4'($urandom_range(0, 15));
    return r;
  endfunction

  task automatic random_run(input int n, input string t);
    logic p0v, p1v, rv;
    logic [3:0] p0rd, p1rd, rrd, qs, qt, crd;
    logic [15:0] p0d, p1d, cd;
    logic e_rsv, e_hz;
    int g;
    p0v = 0; p1v = 0; p0rd = 0; p1rd = 0; p0d = 0; p1d = 0;
    for (int c = 0; c < n; c++) begin
      if (!p0v && ($urandom_range(0, 2) != 0)) begin p0v = 1; p0rd = pick_rd(); p0d = 16'($urandom); end
      if (!p1v && ($urandom_range(0, 2) != 0)) begin p1v = 1; p1rd = pick_rd(); p1d = 16'($urandom); end
      rv = 1'($urandom_range(0, 1));
      rrd = 4'($urandom_range(0, 15));
      qs = 4'($urandom_range(0, 15));
      qt = 4'($urandom_range(0, 15));
      drive(p0v, p0rd, p0d, p1v, p1rd, p1d, rv, rrd, qs, qt);
      #1;
      g = -1;
      if (p0v && p1v) g = (m_last == 0) ? 1 : 0;
      else if (p0v)   g = 0;
      else if (p1v)   g = 1;
      crd = (g == 1) ? p1rd : p0rd;
      cd  = (g == 1) ? p1d : p0d;
      e_rsv = !m_busy[rrd] || (g >= 0 && crd == rrd);
      e_hz  = m_busy[qs] || m_busy[qt];
      comb_chk(t, g == 0, g == 1, e_rsv, e_hz);
      if (g >= 0) begin
        if (!m_busy[crd]) m_sb = 1'b1;
        m_busy[crd] = 1'b0;
        m_last = g; m_we = 1'b1; m_wrd = {1'b0, crd}; m_wd = cd;
        if (g == 0) p0v = 0; else p1v = 0;
      end else m_we = 1'b0;
      if (rv && e_rsv) m_busy[rrd] = 1'b1;
      @(posedge clk); #1;
      seq_chk(t, m_we, m_wrd, m_wd, m_sb);
    end
  endtask

  initial begin
    tbl[0] = mk(0,0,16'h0,     0,0,16'h0,      1,3, 3,0, 0,0,1,0, 0,5'd0,16'h0,   0);
    tbl[1] = mk(1,3,16'h1234,  0,0,16'h0,      0,0, 3,0, 1,0,1,1, 1,5'd3,16'h1234,0);
    tbl[2] = mk(0,0,16'h0,     0,0,16'h0,      0,0, 3,0, 0,0,1,0, 0,5'd3,16'h1234,0);
    tbl[3] = mk(0,0,16'h0,     0,0,16'h0,      1,7, 0,0, 0,0,1,0, 0,5'd3,16'h1234,0);
    tbl[4] = mk(0,0,16'h0,     0,0,16'h0,      1,7, 7,7, 0,0,0,1, 0,5'd3,16'h1234,0);
    tbl[5] = mk(0,0,16'h0,     1,7,16'hBEEF,   1,7, 7,7, 0,1,1,1, 1,5'd7,16'hBEEF,0);
    tbl[6] = mk(0,0,16'h0,     0,0,16'h0,      0,7, 7,0, 0,0,0,1, 0,5'd7,16'hBEEF,0);
    tbl[7] = mk(1,7,16'h0707,  0,0,16'h0,      0,0, 7,0, 1,0,1,1, 1,5'd7,16'h0707,0);
    tbl[8] = mk(0,0,16'h0,     0,0,16'h0,      0,7, 7,0, 0,0,1,0, 0,5'd7,16'h0707,0);

    // Held in reset with everything requesting: nothing may be accepted.
    drive(1, 1, 16'h1111, 1, 2, 16'h2222, 1, 3, 3, 4);
    #12;
    comb_chk("rst", 0, 0, 0, 0);
    seq_chk("rst", 0, 5'd0, 16'h0, 0);

    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v0, tbl[i].rd0, tbl[i].d0, tbl[i].v1, tbl[i].rd1, tbl[i].d1,
            tbl[i].rv, tbl[i].rrd, tbl[i].qs, tbl[i].qt);
      #1;
      comb_chk($sformatf("tbl%0d", i), tbl[i].e_r0, tbl[i].e_r1, tbl[i].e_rsv, tbl[i].e_hz);
      @(posedge clk); #1;
      seq_chk($sformatf("tbl%0d", i), tbl[i].e_we, tbl[i].e_wrd, tbl[i].e_wd, tbl[i].e_sb);
    end

    // Sustained tie alternates starting with req0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 16'h0011, 1, 2, 16'h0022, 0, 0, 0, 0);
      #1;
      chk($sformatf("rr%0d.req0_ready", i), 32'(req0_ready), 32'(i % 2 == 0));
      chk($sformatf("rr%0d.req1_ready", i), 32'(req1_ready), 32'(i % 2 == 1));
      @(posedge clk); #1;
      chk($sformatf("rr%0d.wr_en", i), 32'(wr_en), 32'd1);
      chk($sformatf("rr%0d.wr_rd", i), 32'(wr_rd), (i % 2 == 0) ? 32'd1 : 32'd2);
    end

    // Commit to an unreserved register still writes and latches sb_err.
    do_reset();
    drive(1, 9, 16'h9999, 0, 0, 0, 0, 0, 0, 0);
    #1; chk("err.req0_ready", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    seq_chk("err", 1, 5'd9, 16'h9999, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 4, 16'h4444, 0, 0, 0, 0);
    @(posedge clk); #1;
    seq_chk("err_hold", 1, 5'd4, 16'h4444, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("err_hold2.sb_err", 32'(sb_err), 32'd1);
    rst_n = 1'b0; #1;
    chk("err_clr.sb_err", 32'(sb_err), 32'd0);
    rst_n = 1'b1;

    // Reset mid-write clears outputs without a clock edge.
    do_reset();
    drive(0, 0, 0, 1, 10, 16'hAAAA, 1, 5, 5, 5);
    #1; comb_chk("mid0", 0, 1, 1, 0);
    @(posedge clk); #1;
    seq_chk("mid0", 1, 5'd10, 16'hAAAA, 1);
    drive(1, 6, 16'h6666, 1, 8, 16'h8888, 0, 0, 5, 5);
    #1; chk("mid1.hazard", 32'(hazard), 32'd1);
    rst_n = 1'b0; #1;
    seq_chk("mid_rst", 0, 5'd0, 16'h0, 0);
    comb_chk("mid_rst", 0, 0, 0, 0);
    rst_n = 1'b1; #1;
    chk("mid_rel.req0_ready", 32'(req0_ready), 32'd1);
    chk("mid_rel.req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    seq_chk("mid_rel", 1, 5'd6, 16'h6666, 1);

    do_reset();
    random_run(150, "rndA");
    do_reset();
    random_run(150, "rndB");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
